// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding and default sizing.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned MAX_HOLD_DEF = 8;
  localparam int unsigned HOLD_W       = 4;

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Two-way round-robin choice: on a tie the master that was not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick,
  output logic       any
);

  assign any  = |req;
  assign pick = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (CPU data port, DMA) bus arbiter toward the Bridge with lockable
// grants bounded by MAX_HOLD and a registered read-data return path.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic              clk_from_cpu,
  input  logic              rst_n_from_cpu,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] addr_to_bridge,
  output logic              we_to_bridge,
  output logic [DATA_W-1:0] wdata_to_bridge,
  input  logic [DATA_W-1:0] rdata_from_bridge
);

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [HOLD_W-1:0] hold_max;
  logic              last_gnt, last_gnt_nxt;
  logic              pick, any_req;
  logic              own_sel, own_req, own_lock, oth_req;
  logic              rd0_c, rd1_c;

  assign hold_max = HOLD_W'(MAX_HOLD);

  rr_pick2 u_rr_pick2 (
    .req  ({m1_req, m0_req}),
    .last (last_gnt),
    .pick (pick),
    .any  (any_req)
  );

  // "own" is the master currently holding the grant, "oth" the competitor
  assign own_sel  = (state == GNT1);
  assign own_req  = own_sel ? m1_req  : m0_req;
  assign own_lock = own_sel ? m1_lock : m0_lock;
  assign oth_req  = own_sel ? m0_req  : m1_req;

  assign m0_gnt = (state == GNT0);
  assign m1_gnt = (state == GNT1);

  always_ff @(posedge clk_from_cpu or negedge rst_n_from_cpu) begin
    if (!rst_n_from_cpu) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    hold_cnt_nxt    = hold_cnt;
    last_gnt_nxt    = last_gnt;
    addr_to_bridge  = '0;
    we_to_bridge    = 1'b0;
    wdata_to_bridge = '0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt    = pick ? GNT1 : GNT0;
          hold_cnt_nxt = HOLD_W'(1);
        end
      end
      GNT0, GNT1: begin
        addr_to_bridge  = own_sel ? m1_addr  : m0_addr;
        we_to_bridge    = own_sel ? m1_we    : m0_we;
        wdata_to_bridge = own_sel ? m1_wdata : m0_wdata;
        if (own_req && own_lock && (hold_cnt < hold_max)) begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end else if (oth_req) begin
          state_nxt    = own_sel ? GNT0 : GNT1;
          hold_cnt_nxt = HOLD_W'(1);
          last_gnt_nxt = own_sel;
        end else if (own_req) begin
          hold_cnt_nxt = HOLD_W'(1);
        end else begin
          state_nxt    = IDLE;
          hold_cnt_nxt = '0;
          last_gnt_nxt = own_sel;
        end
      end
      default: begin
        state_nxt    = IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  assign rd0_c = (state == GNT0) && !m0_we;
  assign rd1_c = (state == GNT1) && !m1_we;

  // Read data captured at the end of the granted read cycle, valid for one cycle
  always_ff @(posedge clk_from_cpu or negedge rst_n_from_cpu) begin
    if (!rst_n_from_cpu) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= rd0_c;
      m1_rvalid <= rd1_c;
      if (rd0_c) m0_rdata <= rdata_from_bridge;
      if (rd1_c) m1_rdata <= rdata_from_bridge;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// against a behavioural owner/streak model of the arbitration rules.
module tb_bus_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned MH = 8;

  logic          clk;
  logic          rst_n;
  logic          req   [2];
  logic          lock  [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] rdata_in;
  logic          gnt0, gnt1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  logic [AW-1:0] br_addr;
  logic          br_we;
  logic [DW-1:0] br_wdata;

  int n_cmp;
  int n_err;

  // Reference model: owner of the bus (-1 none), consecutive grant streak, last loser tie-break
  int            m_own;
  int            m_streak;
  int            m_last;
  logic          m_rvalid [2];
  logic [DW-1:0] m_rdata  [2];

  bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_HOLD(MH)) dut (
    .clk_from_cpu      (clk),
    .rst_n_from_cpu    (rst_n),
    .m0_req            (req[0]),
    .m0_lock           (lock[0]),
    .m0_we             (we[0]),
    .m0_addr           (addr[0]),
    .m0_wdata          (wdata[0]),
    .m0_gnt            (gnt0),
    .m0_rvalid         (rv0),
    .m0_rdata          (rd0),
    .m1_req            (req[1]),
    .m1_lock           (lock[1]),
    .m1_we             (we[1]),
    .m1_addr           (addr[1]),
    .m1_wdata          (wdata[1]),
    .m1_gnt            (gnt1),
    .m1_rvalid         (rv1),
    .m1_rdata          (rd1),
    .addr_to_bridge    (br_addr),
    .we_to_bridge      (br_we),
    .wdata_to_bridge   (br_wdata),
    .rdata_from_bridge (rdata_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_own    = -1;
    m_streak = 0;
    m_last   = 1;
    for (int x = 0; x < 2; x++) begin
      m_rvalid[x] = 1'b0;
      m_rdata[x]  = '0;
    end
  endfunction

  function automatic void model_step();
    int o;
    for (int x = 0; x < 2; x++) begin
      m_rvalid[x] = (m_own == x) && !we[x];
      if (m_rvalid[x]) m_rdata[x] = rdata_in;
    end
    if (m_own < 0) begin
      if (req[0] && req[1]) m_own = 1 - m_last;
      else if (req[0])      m_own = 0;
      else if (req[1])      m_own = 1;
      m_streak = (m_own >= 0) ? 1 : 0;
    end else begin
      o = 1 - m_own;
      if (req[m_own] && lock[m_own] && (m_streak < int'(MH))) begin
        m_streak++;
      end else if (req[o]) begin
        m_last   = m_own;
        m_own    = o;
        m_streak = 1;
      end else if (req[m_own]) begin
        m_streak = 1;
      end else begin
        m_last   = m_own;
        m_own    = -1;
        m_streak = 0;
      end
    end
  endfunction

  task automatic check_all(input string ph);
    logic [AW-1:0] ea;
    logic          ew;
    logic [DW-1:0] ed;
    ea = '0;
    ew = 1'b0;
    ed = '0;
    if (m_own >= 0) begin
      ea = addr[m_own];
      ew = we[m_own];
      ed = wdata[m_own];
    end
    check_val({ph, ".gnt0"},   64'(gnt0),     64'(m_own == 0));
    check_val({ph, ".gnt1"},   64'(gnt1),     64'(m_own == 1));
    check_val({ph, ".addr"},   64'(br_addr),  64'(ea));
    check_val({ph, ".we"},     64'(br_we),    64'(ew));
    check_val({ph, ".wdata"},  64'(br_wdata), 64'(ed));
    check_val({ph, ".rvalid0"}, 64'(rv0),     64'(m_rvalid[0]));
    check_val({ph, ".rvalid1"}, 64'(rv1),     64'(m_rvalid[1]));
    check_val({ph, ".rdata0"}, 64'(rd0),      64'(m_rdata[0]));
    check_val({ph, ".rdata1"}, 64'(rd1),      64'(m_rdata[1]));
  endtask

  task automatic check_cycle(input string ph);
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    for (int x = 0; x < 2; x++) begin
      req[x]   = 1'b0;
      lock[x]  = 1'b0;
      we[x]    = 1'b0;
      addr[x]  = '0;
      wdata[x] = '0;
    end
    rdata_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    int n_we;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    do_reset();

    // Single m0 read: grant in cycle 2, data back in cycle 3
    req[0] = 1'b1; addr[0] = 32'h0000_0040; rdata_in = 32'hDEAD_BEEF;
    check_cycle("rd.c1");
    check_val("rd.c1_nognt", 64'(gnt0), 64'(0));
    advance();
    req[0] = 1'b0;
    check_cycle("rd.c2");
    check_val("rd.c2_gnt", 64'(gnt0), 64'(1));
    advance();
    check_cycle("rd.c3");
    check_val("rd.c3_rvalid", 64'(rv0), 64'(1));
    check_val("rd.c3_rdata", 64'(rd0), 64'(32'hDEAD_BEEF));
    advance();
    check_cycle("rd.c4");
    check_val("rd.c4_rvalid", 64'(rv0), 64'(0));
    advance();

    // Simultaneous unlocked requests alternate starting with m0
    do_reset();
    req[0] = 1'b1; req[1] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      check_cycle("tie");
      check_val($sformatf("tie.c%0d_g0", c), 64'(gnt0), 64'(c >= 2 && (c % 2) == 0));
      check_val($sformatf("tie.c%0d_g1", c), 64'(gnt1), 64'(c >= 2 && (c % 2) == 1));
      advance();
    end

    // Locked m1 keeps the bus for MAX_HOLD cycles, then m0 gets one cycle
    do_reset();
    req[1] = 1'b1; lock[1] = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      if (c == 2) req[0] = 1'b1;
      check_cycle("hold");
      check_val($sformatf("hold.c%0d_g1", c), 64'(gnt1),
                64'((c >= 2 && c <= 1 + int'(MH)) || c == 3 + int'(MH)));
      check_val($sformatf("hold.c%0d_g0", c), 64'(gnt0), 64'(c == 2 + int'(MH)));
      advance();
    end
    clear_inputs();
    repeat (2) begin
      check_cycle("drain");
      advance();
    end

    // m0 write: exactly one bridge write cycle, no read valid
    n_we = 0;
    we[0] = 1'b1; addr[0] = 32'h0000_0100; wdata[0] = 32'h1234_5678;
    for (int c = 1; c <= 4; c++) begin
      req[0] = (c == 1);
      check_cycle("wr");
      if (br_we) n_we++;
      if (c == 2) begin
        check_val("wr.addr", 64'(br_addr), 64'(32'h0000_0100));
        check_val("wr.wdata", 64'(br_wdata), 64'(32'h1234_5678));
      end
      check_val($sformatf("wr.c%0d_rvalid", c), 64'(rv0), 64'(0));
      advance();
    end
    check_val("wr.we_cycles", 64'(n_we), 64'(1));

    // Reset asserted in the middle of an m1 write cycle
    clear_inputs();
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0000_0200; wdata[1] = 32'hCAFE_0001;
    check_cycle("rstw.c1");
    advance();
    req[1] = 1'b0;
    check_cycle("rstw.c2");
    check_val("rstw.we_before", 64'(br_we), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rstw.we_drop", 64'(br_we), 64'(0));
    check_val("rstw.gnt1_drop", 64'(gnt1), 64'(0));
    check_val("rstw.addr_drop", 64'(br_addr), 64'(0));
    do_reset();
    req[0] = 1'b1; req[1] = 1'b1;
    check_cycle("rstw.tie1");
    advance();
    check_cycle("rstw.tie2");
    check_val("rstw.first_m0", 64'(gnt0), 64'(1));
    check_val("rstw.first_not_m1", 64'(gnt1), 64'(0));
    advance();

    // Randomized traffic; pending requests stay stable until granted
    clear_inputs();
    for (int c = 0; c < 3000; c++) begin
      for (int x = 0; x < 2; x++) begin
        if (m_own == x) begin
          req[x]  = ($urandom_range(0, 99) < 85);
          lock[x] = ($urandom_range(0, 99) < 85);
        end else if (!req[x]) begin
          req[x]   = ($urandom_range(0, 99) < 40);
          lock[x]  = ($urandom_range(0, 99) < 60);
          we[x]    = 1'($urandom_range(0, 1));
          addr[x]  = $urandom;
          wdata[x] = $urandom;
        end
      end
      rdata_in = $urandom;
      check_cycle("rnd");
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk_from_cpu and rst_n_from_cpu.
REQ-002 Parameter DATA_W, default 32: data width of all wdata/rdata ports.
REQ-003 Parameter ADDR_W, default 32: address width of all addr ports.
REQ-004 Parameter MAX_HOLD, default 8, legal range 1..15: maximum consecutive locked grant cycles while the other master waits.
REQ-005 clk_from_cpu  in  1  system clock; all state updates on its rising edge.
REQ-006 rst_n_from_cpu  in  1  asynchronous reset, active low.
REQ-007 mX_req  in  1  master X (X = 0 CPU data port, X = 1 DMA) requests one bus access.
REQ-008 mX_lock  in  1  master X asks to keep the grant for its next access.
REQ-009 mX_we  in  1  access is a write.
REQ-010 mX_addr  in  ADDR_W  access address.
REQ-011 mX_wdata  in  DATA_W  write data.
REQ-012 mX_gnt  out  1  master X owns the bus this cycle.
REQ-013 mX_rvalid  out  1  mX_rdata holds the read result of master X's previous granted read.
REQ-014 mX_rdata  out  DATA_W  registered read data.
REQ-015 addr_to_bridge  out  ADDR_W  address toward the Bridge.
REQ-016 we_to_bridge  out  1  write enable toward the Bridge.
REQ-017 wdata_to_bridge  out  DATA_W  write data toward the Bridge.
REQ-018 rdata_from_bridge  in  DATA_W  combinational read data from the Bridge.

Function
REQ-019 FSM states: IDLE, GNT0, GNT1, held in a registered state; mX_gnt = (state == GNTX), decoded with no combinational path from any input.
REQ-020 In GNTX, addr/we/wdata_to_bridge SHALL equal master X's signals combinationally; in IDLE they SHALL be 0.
REQ-021 A master SHALL hold req/we/addr/wdata stable from req assertion until the cycle in which it sees gnt; one granted cycle completes exactly one access.
REQ-022 Transition from IDLE: both req -> grant the master that is not last_gnt; one req -> grant that master; none -> stay in IDLE.
REQ-023 Transition from GNTX, evaluated in priority order:
  (a) mX_req & mX_lock & hold_cnt < MAX_HOLD -> GNTX, hold_cnt + 1.
  (b) else if the other master's req -> GNT(other), hold_cnt = 1, last_gnt = X.
  (c) else if mX_req -> GNTX, hold_cnt = 1.
  (d) else -> IDLE, hold_cnt = 0, last_gnt = X.
REQ-024 Entering any GNT state from IDLE SHALL set hold_cnt = 1; hold_cnt is 4 bits wide and SHALL never exceed MAX_HOLD.
REQ-025 Read latency: on a GNTX cycle with mX_we = 0, rdata_from_bridge SHALL be registered into mX_rdata, and mX_rvalid SHALL be 1 on the next cycle only.
REQ-026 mX_rvalid SHALL be 0 after a write cycle or a non-granted cycle; mX_rdata SHALL hold its last value when not updated.
REQ-027 Simultaneous requests with last_gnt = 1 SHALL grant m0, so m0 wins the first tie after reset; back-to-back ties SHALL alternate.
REQ-028 A locked master that reaches MAX_HOLD while the other requests SHALL lose the grant on the next cycle; with no competing request it SHALL continue through (c).

Reset
REQ-029 Asserting rst_n_from_cpu low SHALL immediately force: state = IDLE, last_gnt = 1, hold_cnt = 0, all gnt/rvalid = 0, all rdata = 0, and all bridge outputs = 0, with a write in flight dropped in the same cycle.
REQ-030 After reset deasserts, the first grant SHALL appear no earlier than one cycle after a req is sampled.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2) and the default DATA_W, ADDR_W and MAX_HOLD.
REQ-032 One sub-module, rr_pick2, SHALL implement the 2-way round-robin choice (inputs: req[1:0], last; outputs: pick, any).

Verification
REQ-033 Only m0 reads 0x0000_0040 with bridge data 0xDEAD_BEEF -> m0_gnt is high in cycle 2, m0_rvalid is high in cycle 3 with m0_rdata = 0xDEAD_BEEF.
REQ-034 Both masters request simultaneously after reset, unlocked -> grants go m0, m1, m0, m1 on consecutive cycles.
REQ-035 m1 locked and requesting continuously, m0 requesting, MAX_HOLD = 8 -> m1_gnt lasts exactly 8 cycles, then m0_gnt for 1 cycle.
REQ-036 m0 writes 0x1234_5678 to 0x0000_0100 -> we_to_bridge = 1 for exactly one cycle with the matching addr/wdata; m0_rvalid stays 0.
REQ-037 Reset pulled low mid-GNT1 write -> we_to_bridge and m1_gnt drop immediately, before the next clock edge; after release, simultaneous requests grant m0 first.
